fiber_dram_port: RTL

- Memory-side stage directly downstream of the fiberBank DRAM crossbar ports.
- Accepts miss-fetch read requests and dirty-line writebacks from one bank.
- Arbitrates them onto a single DRAM command channel.
- Returns read data to the bank's fill port in order, through a credit-guarded response FIFO, so DRAM responses never need backpressure.

---
 rtl/fiber_dram_port_if.sv | 41 ++++
 rtl/fiber_dram_port.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fiber_dram_port_if.sv
// Bank-side and DRAM-side handshake bundle for fiber_dram_port.
// The slave modport is the port block's view; master is the view of whatever drives it.
interface fiber_dram_port_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] i_bank_rd_addr;
  logic                  i_bank_rd_valid;
  logic                  o_bank_rd_ready;
  logic [DATA_WIDTH-1:0] o_bank_fill_data;
  logic                  o_bank_fill_valid;
  logic                  i_bank_fill_ready;
  logic [ADDR_WIDTH-1:0] i_bank_wb_addr;
  logic [DATA_WIDTH-1:0] i_bank_wb_data;
  logic                  i_bank_wb_valid;
  logic                  o_bank_wb_ready;
  logic                  o_mem_cmd_valid;
  logic                  i_mem_cmd_ready;
  logic                  o_mem_cmd_we;
  logic [ADDR_WIDTH-1:0] o_mem_cmd_addr;
  logic [DATA_WIDTH-1:0] o_mem_cmd_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rsp_data;
  logic                  i_mem_rsp_valid;
  logic                  o_err;

  modport slave (
    input  i_bank_rd_addr, i_bank_rd_valid, i_bank_fill_ready,
           i_bank_wb_addr, i_bank_wb_data, i_bank_wb_valid,
           i_mem_cmd_ready, i_mem_rsp_data, i_mem_rsp_valid,
    output o_bank_rd_ready, o_bank_fill_data, o_bank_fill_valid, o_bank_wb_ready,
           o_mem_cmd_valid, o_mem_cmd_we, o_mem_cmd_addr, o_mem_cmd_wdata, o_err
  );

  modport master (
    output i_bank_rd_addr, i_bank_rd_valid, i_bank_fill_ready,
           i_bank_wb_addr, i_bank_wb_data, i_bank_wb_valid,
           i_mem_cmd_ready, i_mem_rsp_data, i_mem_rsp_valid,
    input  o_bank_rd_ready, o_bank_fill_data, o_bank_fill_valid, o_bank_wb_ready,
           o_mem_cmd_valid, o_mem_cmd_we, o_mem_cmd_addr, o_mem_cmd_wdata, o_err
  );
endinterface

// File: rtl/fiber_dram_port.sv
// Memory-side port for one fiber bank: arbitrates miss fetches and writebacks
// onto one DRAM command channel and returns read data in order through a
// credit-guarded response FIFO, so DRAM responses never need backpressure.
module fiber_dram_port #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 16,
  parameter int RSP_DEPTH    = 4,
  parameter int WB_BURST_MAX = 4
) (
  input logic          i_clk,
  input logic          i_nreset,
  fiber_dram_port_if.slave bus
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int SW = $clog2(WB_BURST_MAX + 1);

  logic                  cmd_valid_q, cmd_valid_d, cmd_we_q, cmd_we_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [CW-1:0]         inflight_q, inflight_d, count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  err_q, err_d;

  logic       cmd_fire, cmd_free, fifo_nempty, pop, push, credit_ok;
  logic       rd_elig, wb_elig, grant_rd, grant_wr;
  logic [CW:0] reserved;

  // Handshake decode and same-cycle arbitration. A read sitting in the command
  // register already owns a FIFO slot, so it is counted against the credits
  // alongside reads in flight and words buffered.
  always_comb begin
    cmd_fire    = cmd_valid_q && bus.i_mem_cmd_ready;
    cmd_free    = !cmd_valid_q || bus.i_mem_cmd_ready;
    reserved    = (CW+1)'(inflight_q) + (CW+1)'(count_q) + (CW+1)'(cmd_valid_q && !cmd_we_q);
    credit_ok   = reserved < (CW+1)'(RSP_DEPTH);
    rd_elig     = i_nreset && bus.i_bank_rd_valid && cmd_free && credit_ok;
    wb_elig     = i_nreset && bus.i_bank_wb_valid && cmd_free;
    grant_rd    = rd_elig && (!wb_elig || streak_q == SW'(WB_BURST_MAX));
    grant_wr    = wb_elig && !grant_rd;
    fifo_nempty = count_q != '0;
    pop         = fifo_nempty && bus.i_bank_fill_ready;
    push        = bus.i_mem_rsp_valid && (inflight_q != '0);
  end

  // Next-state for command register, counters, FIFO and error flag
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if (cmd_fire) cmd_valid_d = 1'b0;
    if (grant_rd || grant_wr) begin
      cmd_valid_d = 1'b1;
      cmd_we_d    = grant_wr;
      cmd_addr_d  = grant_wr ? bus.i_bank_wb_addr : bus.i_bank_rd_addr;
      cmd_wdata_d = grant_wr ? bus.i_bank_wb_data : '0;
    end

    // Streak only counts writes that jumped ahead of a waiting read; it
    // saturates so a credit-starved read does not wrap it.
    streak_d = streak_q;
    if (grant_rd || !bus.i_bank_rd_valid) streak_d = '0;
    else if (grant_wr && streak_q != SW'(WB_BURST_MAX)) streak_d = streak_q + SW'(1);

    inflight_d = inflight_q;
    if (cmd_fire && !cmd_we_q) inflight_d = inflight_d + CW'(1);
    if (push)                  inflight_d = inflight_d - CW'(1);

    count_d = count_q;
    if (push) count_d = count_d + CW'(1);
    if (pop)  count_d = count_d - CW'(1);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.i_mem_rsp_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    // last_q keeps the most recently delivered word on the bus once empty
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      last_d   = mem_q[rd_ptr_q];
    end

    err_d = err_q || (bus.i_mem_rsp_valid && inflight_q == '0);
  end

  // State registers, async active-low reset
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
      last_q      <= '0;
      streak_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      last_q      <= last_d;
      streak_q    <= streak_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_bank_rd_ready   = grant_rd;
  assign bus.o_bank_wb_ready   = grant_wr;
  assign bus.o_mem_cmd_valid   = cmd_valid_q;
  assign bus.o_mem_cmd_we      = cmd_we_q;
  assign bus.o_mem_cmd_addr    = cmd_addr_q;
  assign bus.o_mem_cmd_wdata   = cmd_wdata_q;
  assign bus.o_bank_fill_valid = fifo_nempty;
  assign bus.o_bank_fill_data  = fifo_nempty ? mem_q[rd_ptr_q] : last_q;
  assign bus.o_err             = err_q;
endmodule
